// File: rtl/data_bus_controller.sv
// Load/store front end from the memory stage to the shared data bus: one-cycle load stall,
// flash write protection, optional misaligned-access trap (define DBC_MISALIGN_TRAP_EN).
module data_bus_controller #(
    parameter logic [31:0] FLASH_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    output logic        stall,
    output logic        stall_lw,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        err_store_flash,
    output logic        err_misaligned,
    inout  wire  [31:0] data_bus_data,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode,
    output logic [1:0]  data_bus_reqw,
    output logic        data_bus_reqs
);

    typedef enum logic {IDLE, LOAD_DATA} state_t;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  width_q, width_d;
    logic        signed_q, signed_d;
    logic        err_flash_q, err_flash_d;
    logic        err_mis_q, err_mis_d;

    logic        misaligned;
    logic        drive_en;
    logic [31:0] wdata_rep;

    always_comb begin
        misaligned = 1'b0;
`ifdef DBC_MISALIGN_TRAP_EN
        case (req_width)
            2'b00:   misaligned = (req_addr[1:0] != 2'b00);
            2'b10:   misaligned = 1'b0;
            default: misaligned = (req_addr[1:0] == 2'b11);
        endcase
`endif
    end

    always_comb begin
        case (req_width)
            2'b00:   wdata_rep = req_wdata;
            2'b10:   wdata_rep = {4{req_wdata[7:0]}};
            default: wdata_rep = {2{req_wdata[15:0]}};
        endcase
    end

    // Outputs are gated by reset so an asserted reset forces the idle bus immediately,
    // even while the pipeline still holds a request.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        width_d       = width_q;
        signed_d      = signed_q;
        err_flash_d   = 1'b0;
        err_mis_d     = 1'b0;
        stall         = 1'b0;
        stall_lw      = 1'b0;
        load_valid    = 1'b0;
        load_data     = 32'h0;
        drive_en      = 1'b0;
        data_bus_addr = 32'h0;
        data_bus_mode = MODE_IDLE;
        data_bus_reqw = 2'b00;
        data_bus_reqs = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (req_valid && misaligned) begin
                        err_mis_d = 1'b1;
                    end else if (req_valid && !req_write) begin
                        stall         = 1'b1;
                        stall_lw      = 1'b1;
                        data_bus_mode = MODE_READ;
                        data_bus_addr = req_addr;
                        data_bus_reqw = req_width;
                        data_bus_reqs = req_signed;
                        addr_d        = req_addr;
                        width_d       = req_width;
                        signed_d      = req_signed;
                        state_d       = LOAD_DATA;
                    end else if (req_valid && req_addr >= FLASH_LIMIT) begin
                        drive_en      = 1'b1;
                        data_bus_mode = MODE_WRITE;
                        data_bus_addr = req_addr;
                        data_bus_reqw = req_width;
                        data_bus_reqs = req_signed;
                    end else if (req_valid) begin
                        err_flash_d = 1'b1;
                    end
                end
                LOAD_DATA: begin
                    // req_valid here is the retiring load itself; never re-issue it.
                    data_bus_mode = MODE_READ;
                    data_bus_addr = addr_q;
                    data_bus_reqw = width_q;
                    data_bus_reqs = signed_q;
                    load_valid    = 1'b1;
                    load_data     = data_bus_data;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_bus_data   = drive_en ? wdata_rep : 32'bz;
    assign err_store_flash = err_flash_q;
    assign err_misaligned  = err_mis_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            width_q     <= 2'b00;
            signed_q    <= 1'b0;
            err_flash_q <= 1'b0;
            err_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            width_q     <= width_d;
            signed_q    <= signed_d;
            err_flash_q <= err_flash_d;
            err_mis_q   <= err_mis_d;
        end
    end

endmodule
